// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/result handshake bundle for nibble_serial_add_ctrl.
// master = requesting unit, slave = the controller.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract performed one nibble per cycle on an external shared
// 4-bit adder, with the carry chained through a register between nibbles.
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  nibble_serial_add_ctrl_if.slave  io,
  output logic [3:0]               add_x,
  output logic [3:0]               add_y,
  output logic                     add_cin,
  input  logic [3:0]               add_sum,
  input  logic                     add_cout
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    add_x       = '0;
    add_y       = '0;
    add_cin     = 1'b0;

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d        = io.in_a;
          b_d        = io.in_sub ? ~io.in_b : io.in_b;
          carry_d    = io.in_sub | io.in_cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        add_x   = a_q[{idx_q, 2'b00} +: 4];
        add_y   = b_q[{idx_q, 2'b00} +: 4];
        add_cin = carry_q;
        sum_d[{idx_q, 2'b00} +: 4] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST) begin
          // Flags come from the live top-nibble adder response so they are
          // registered together with the final sum nibble.
          state_d     = DONE;
          out_valid_d = 1'b1;
          cout_d      = add_cout;
          ovf_d       = (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_sum   = sum_q;
  assign io.out_cout  = cout_q;
  assign io.out_ovf   = ovf_q;
endmodule
